// File: rtl/shift_add_mul_ctrl_if.sv
// Handshake and operand/result bundle between the top-level control and the
// shift-and-add multiply sequencer.
interface shift_add_mul_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic               start;
  logic               abort;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               ld_a;
  logic               ld_b;
  logic               ld_o;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic [CNT_W-1:0]   step;

  modport master (
    output start, abort, a_in, b_in,
    input  ld_a, ld_b, ld_o, busy, done, product, step
  );

  modport slave (
    input  start, abort, a_in, b_in,
    output ld_a, ld_b, ld_o, busy, done, product, step
  );
endinterface

// File: rtl/shift_add_mul_ctrl.sv
// Unsigned shift-and-add multiply sequencer: WIDTH iterations into a 2*WIDTH
// product register, with start/abort/busy/done handshaking and load strobes.
module shift_add_mul_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_add_mul_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   step_q;
  logic [2*WIDTH-1:0] product_q;

  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] acc_d;
  logic               accept;
  logic               last_iter;

  assign partial   = mplier_q[0] ? mcand_q : '0;
  assign acc_d     = acc_q + partial;
  assign accept    = !reset && (state_q == S_IDLE) && bus.start;
  // abort beats the final-iteration load, so ld_o is suppressed with it
  assign last_iter = !reset && (state_q == S_RUN) && !bus.abort && (step_q == LAST_STEP);

  assign bus.ld_a    = accept;
  assign bus.ld_b    = accept;
  assign bus.ld_o    = last_iter;
  assign bus.busy    = (state_q == S_RUN);
  assign bus.done    = (state_q == S_DONE);
  assign bus.product = product_q;
  assign bus.step    = step_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      step_q    <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            mcand_q  <= {{WIDTH{1'b0}}, bus.a_in};
            mplier_q <= bus.b_in;
            acc_q    <= '0;
            step_q   <= '0;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            state_q <= S_IDLE;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            step_q   <= step_q + 1'b1;
            if (step_q == LAST_STEP) begin
              product_q <= acc_d;
              state_q   <= S_DONE;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Directed bench for shift_add_mul_ctrl: operand table plus hand-written
// sequences for held start, mid-run disturbance, abort and reset-in-run.
module tb_shift_add_mul_ctrl;
  localparam int W = 4;
  localparam int C = 3;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  shift_add_mul_ctrl_if #(.WIDTH(W), .CNT_W(C)) bus ();

  shift_add_mul_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation from IDLE; operands are scrambled during RUN to prove
  // they are only sampled at the accept edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input string nm);
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    #1;
    chk({nm, ".ld_a"}, 32'(bus.ld_a), 1);
    chk({nm, ".ld_b"}, 32'(bus.ld_b), 1);
    tick();
    bus.start = 1'b0;
    bus.a_in  = ~a;
    bus.b_in  = ~b;
    for (int i = 0; i < W; i++) begin
      #1;
      chk({nm, ".busy"}, 32'(bus.busy), 1);
      chk({nm, ".step"}, 32'(bus.step), 32'(i));
      chk({nm, ".ld_o"}, 32'(bus.ld_o), (i == W-1) ? 1 : 0);
      chk({nm, ".done_run"}, 32'(bus.done), 0);
      tick();
    end
    chk({nm, ".done"}, 32'(bus.done), 1);
    chk({nm, ".busy_done"}, 32'(bus.busy), 0);
    chk({nm, ".product"}, 32'(bus.product), 32'(exp));
    tick();
    chk({nm, ".done_clr"}, 32'(bus.done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    int first_c;
    int second_c;
    logic [2*W-1:0] p1;
    logic [2*W-1:0] p2;

    vecs[0] = '{a: 4'd3,  b: 4'd5,  p: 8'd15};
    vecs[1] = '{a: 4'd15, b: 4'd15, p: 8'hE1};
    vecs[2] = '{a: 4'd0,  b: 4'd9,  p: 8'd0};
    vecs[3] = '{a: 4'd9,  b: 4'd1,  p: 8'd9};
    vecs[4] = '{a: 4'd1,  b: 4'd0,  p: 8'd0};

    // Reset: strobes stay low even with start asserted
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.abort = 1'b0;
    bus.a_in  = 4'd3;
    bus.b_in  = 4'd3;
    tick();
    tick();
    chk("rst.ld_a", 32'(bus.ld_a), 0);
    chk("rst.ld_o", 32'(bus.ld_o), 0);
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.done", 32'(bus.done), 0);
    chk("rst.product", 32'(bus.product), 0);
    chk("rst.step", 32'(bus.step), 0);
    bus.start = 1'b0;
    reset     = 1'b0;
    tick();
    chk("idle.busy", 32'(bus.busy), 0);

    for (int k = 0; k < 5; k++)
      run_op(vecs[k].a, vecs[k].b, vecs[k].p, $sformatf("vec%0d", k));

    // Start held high: (2,7) then (4,4), back-to-back accepts
    bus.a_in  = 4'd2;
    bus.b_in  = 4'd7;
    bus.start = 1'b1;
    tick();
    bus.a_in = 4'd4;
    bus.b_in = 4'd4;
    dones = 0; first_c = -1; second_c = -1; p1 = '0; p2 = '0;
    for (int c = 1; c <= 20; c++) begin
      if (bus.done) begin
        dones++;
        if (dones == 1) begin first_c = c; p1 = bus.product; end
        if (dones == 2) begin second_c = c; p2 = bus.product; bus.start = 1'b0; end
      end
      tick();
    end
    chk("held.dones", 32'(dones), 2);
    chk("held.first_cycle", 32'(first_c), 5);
    chk("held.second_cycle", 32'(second_c), 11);
    chk("held.p1", 32'(p1), 14);
    chk("held.p2", 32'(p2), 16);
    chk("held.idle", 32'(bus.busy), 0);

    // 6x3 with a start pulse and operand change in RUN cycle 2
    bus.a_in  = 4'd6;
    bus.b_in  = 4'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= W; c++) begin
      if (c == 2) begin bus.start = 1'b1; bus.a_in = 4'd15; bus.b_in = 4'd15; end
      else bus.start = 1'b0;
      #1;
      chk("dist.busy", 32'(bus.busy), 1);
      tick();
    end
    bus.start = 1'b0;
    chk("dist.done", 32'(bus.done), 1);
    chk("dist.product", 32'(bus.product), 18);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("dist.no_extra", 32'(bus.busy | bus.done), 0);
    end

    // Abort in RUN cycle 2 of 7x7 after a 15 result
    run_op(4'd3, 4'd5, 8'd15, "pre_abort");
    bus.a_in  = 4'd7;
    bus.b_in  = 4'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.abort = 1'b1;
    #1;
    chk("abort.busy_before", 32'(bus.busy), 1);
    chk("abort.ld_o", 32'(bus.ld_o), 0);
    tick();
    bus.abort = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("abort.busy", 32'(bus.busy), 0);
      chk("abort.done", 32'(bus.done), 0);
      chk("abort.ld_o_idle", 32'(bus.ld_o), 0);
      chk("abort.product", 32'(bus.product), 15);
      tick();
    end

    // Reset in RUN of 5x5, then a clean 5x5
    bus.a_in  = 4'd5;
    bus.b_in  = 4'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("rrun.ld_o", 32'(bus.ld_o), 0);
    tick();
    reset = 1'b0;
    chk("rrun.busy", 32'(bus.busy), 0);
    chk("rrun.done", 32'(bus.done), 0);
    chk("rrun.product", 32'(bus.product), 0);
    chk("rrun.step", 32'(bus.step), 0);
    run_op(4'd5, 4'd5, 8'd25, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_add_mul_ctrl.md
Name: shift_add_mul_ctrl

Overview:
- Sequencer for the A/B/O register datapath: runs an unsigned shift-and-add multiply of two WIDTH-bit operands into a 2*WIDTH-bit result register.
- Sits between the operand registers and the output register. Provides the register load strobes and start/busy/done handshaking to the top-level control.
- Contains its own multiplicand shift register, multiplier shift register, accumulator, iteration counter and FSM.

Parameters:
- WIDTH, 4, operand width in bits; the product is 2*WIDTH bits.
- CNT_W, 3, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- abort  input  1  cancel an in-progress multiply; sampled only in RUN.
- a_in  input  WIDTH  multiplicand operand.
- b_in  input  WIDTH  multiplier operand.
- ld_a  output  1  combinational strobe; A operand captured this edge.
- ld_b  output  1  combinational strobe; B operand captured this edge.
- ld_o  output  1  combinational strobe; product register loaded this edge.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle completion pulse; high while state is DONE.
- product  output  2*WIDTH  registered result; holds the last completed value.
- step  output  CNT_W  current iteration index; debug/verification visibility.

Behaviour:
- Reset is synchronous and active-high, with priority over every other input.
- Reset values: state=IDLE, product=0, accumulator=0, multiplicand=0, multiplier=0, step=0.
- Reset forces busy=0, done=0, ld_a=ld_b=ld_o=0.
- FSM states: IDLE, RUN, DONE. Encoding is free.
- IDLE behaviour:
  - ld_a = ld_b = start.
  - On an edge with start=1:
    - mcand <= zero-extended a_in (2*WIDTH bits).
    - mplier <= b_in.
    - acc <= 0.
    - step <= 0.
    - state <= RUN.
  - start=0: hold all state.
- RUN behaviour, each edge with abort=0:
  - acc <= acc + (mplier[0] ? mcand : 0), computed at 2*WIDTH bits. No overflow is possible.
  - mcand <= mcand << 1.
  - mplier <= mplier >> 1, zero-filled.
  - step <= step + 1.
- RUN termination:
  - When step == WIDTH-1, this is the final iteration: ld_o=1 combinationally.
  - product <= final accumulated value, i.e. acc plus the final partial product.
  - state <= DONE.
- RUN with abort=1:
  - state <= IDLE.
  - product unchanged; no done pulse; ld_o=0.
  - abort takes priority over the final-iteration load.
- DONE behaviour:
  - done=1 for exactly one cycle, then state <= IDLE unconditionally.
  - start during DONE is ignored; it must be re-presented in IDLE.
- Latency: start sampled at edge T gives RUN during cycles T+1..T+WIDTH (busy=1).
  - product updated at edge T+WIDTH.
  - done=1 in the cycle after edge T+WIDTH.
  - Earliest next accept is edge T+WIDTH+2.
  - The full operation is WIDTH+1 cycles from accept to the done cycle.
- No early termination: a zero multiplier still runs all WIDTH iterations.
- Operands are sampled only at the accept edge. Changes to a_in/b_in during RUN have no effect.
- start during RUN is ignored. It is not queued.
- abort outside RUN is ignored.
- product is stable except at the ld_o edge or reset. It holds across aborts and idle periods.
- Reset during RUN or DONE returns to IDLE next edge, with product=0 and no done.
- ld_a, ld_b and ld_o are never asserted while reset=1.

Test Plan:
- Reset, then a_in=3, b_in=5, start pulse at edge T.
  - ld_a=ld_b=1 at T; busy=1 for cycles T+1..T+4.
  - ld_o=1 in cycle T+4; product=15 and done=1 in cycle T+5; busy=0.
- Corner operands:
  - a_in=15, b_in=15 gives product=225 (0xE1).
  - a_in=0, b_in=9 gives product=0 with the full 4-cycle RUN.
  - a_in=9, b_in=1 gives product=9.
- Start held high continuously with operands (2,7) then (4,4):
  - First done gives product=14.
  - IDLE is re-entered one cycle after done; the second accept gives product=16.
  - Exactly one done per operation.
- Start pulsed and operands changed during RUN of 6x3:
  - product=18, no extra operation started, busy never glitches.
- Abort asserted in RUN cycle 2 of 7x7, after a previous result of 15:
  - Returns to IDLE; product stays 15; done never asserted; ld_o never asserted.
- Reset asserted during RUN of 5x5:
  - Next cycle state=IDLE, product=0, busy=0, done=0.
  - A subsequent 5x5 gives product=25.
